tx_shift_datapath: RTL and testbench

Double-buffered transmit datapath for the I2C transmitter, sitting directly downstream of `tx_controller` and executing its buffer/counter commands. It holds a small byte FIFO fed by the host, two 8-bit ping-pong shift buffers, and the bit counters (`TXCount`, `ICount`) that the controller reads back. It produces the serial bit stream and a per-bit valid strobe for the line driver.

---
 rtl/tx_pkg.sv | 10 +
 rtl/tx_byte_fifo.sv | 55 +++++
 rtl/tx_shift_datapath.sv | 142 ++++++++++++++
 tb/tb_tx_shift_datapath.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and widths for the I2C transmit datapath.
// Pure declarations; no logic, latency or flow control of its own.
// Holds the byte width default and the counter widths the controller reads back.
package tx_pkg;
    localparam int DATA_W    = 8;
    localparam int TXCOUNT_W = 7;
    localparam int ICOUNT_W  = 3;

    typedef logic [DATA_W-1:0] tx_byte_t;
endpackage

// File: rtl/tx_byte_fifo.sv
// Host byte FIFO with a dual-entry read port so both shift buffers can load in one cycle.
// Latency: a pushed byte is visible at head one cycle after acceptance (no bypass).
// Backpressure: push is ignored while full; pops of 0..2 entries always proceed.
module tx_byte_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic [1:0]   pop_n,
    output logic [W-1:0] head,
    output logic [W-1:0] head1,
    output logic         empty,
    output logic         full,
    output logic         has2
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   count;
    logic [AW-1:0] raddr1;
    logic          push_ok;

    assign count   = wptr - rptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign has2    = (count >= (AW+1)'(2));
    assign push_ok = push && !full;
    assign raddr1  = rptr[AW-1:0] + AW'(1);
    assign head    = mem[rptr[AW-1:0]];
    assign head1   = mem[raddr1];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + (AW+1)'(1);
            end
            rptr <= rptr + (AW+1)'(pop_n);
        end
    end

    // Storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end
endmodule

// File: rtl/tx_shift_datapath.sv
// Double-buffered I2C transmit datapath: host FIFO, two ping-pong shift buffers, bit counters.
// Latency: every command lands at the next rising edge; txbit/txbit_valid are registered.
// Backpressure: wr_ready drops at full; loads from an empty FIFO insert 0x00 and set underrun.
// Build option TX_LSB_FIRST_EN switches the shift direction to LSB-first.
module tx_shift_datapath
    import tx_pkg::*;
#(
    parameter int DATA_W     = tx_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 LoadTXBuf0,
    input  logic                 LoadTXBuf1,
    input  logic                 ShiftTXBuf0,
    input  logic                 ShiftTXBuf1,
    input  logic                 LoadTXCount,
    input  logic                 DecTXCount,
    input  logic                 validdata,
    input  logic                 underrun_clr,
    output logic                 txbit,
    output logic                 txbit_valid,
    output logic [TXCOUNT_W-1:0] TXCount,
    output logic [ICOUNT_W-1:0]  ICount,
    output logic                 fifo_empty,
    output logic                 underrun
);
    logic [DATA_W-1:0] buf0, buf1;
    logic [DATA_W-1:0] head, head1;
    logic [DATA_W-1:0] ld0_val, ld1_val;
    logic [DATA_W-1:0] sh0_val, sh1_val;
    logic              out0, out1;
    logic              empty, full, has2;
    logic [1:0]        pop_n;
    logic              ld_under;
    logic              sh0, sh1;

    assign wr_ready   = !full;
    assign fifo_empty = empty;

    tx_byte_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop_n     (pop_n),
        .head      (head),
        .head1     (head1),
        .empty     (empty),
        .full      (full),
        .has2      (has2)
    );

    // Load values and pop count; a dual load takes head and the entry behind it.
    always_comb begin
        pop_n    = 2'd0;
        ld_under = 1'b0;
        ld0_val  = '0;
        ld1_val  = '0;
        if (LoadTXBuf0 && LoadTXBuf1) begin
            pop_n    = empty ? 2'd0 : (has2 ? 2'd2 : 2'd1);
            ld_under = !has2;
            ld0_val  = empty ? '0 : head;
            ld1_val  = has2 ? head1 : '0;
        end else if (LoadTXBuf0) begin
            pop_n    = empty ? 2'd0 : 2'd1;
            ld_under = empty;
            ld0_val  = empty ? '0 : head;
        end else if (LoadTXBuf1) begin
            pop_n    = empty ? 2'd0 : 2'd1;
            ld_under = empty;
            ld1_val  = empty ? '0 : head;
        end
    end

    // Buffer 0 owns the shifter when both are requested; a load blocks its buffer's shift.
    assign sh0 = ShiftTXBuf0 && !LoadTXBuf0;
    assign sh1 = ShiftTXBuf1 && !ShiftTXBuf0 && !LoadTXBuf1;

`ifdef TX_LSB_FIRST_EN
    assign out0    = buf0[0];
    assign out1    = buf1[0];
    assign sh0_val = {1'b0, buf0[DATA_W-1:1]};
    assign sh1_val = {1'b0, buf1[DATA_W-1:1]};
`else
    assign out0    = buf0[DATA_W-1];
    assign out1    = buf1[DATA_W-1];
    assign sh0_val = {buf0[DATA_W-2:0], 1'b0};
    assign sh1_val = {buf1[DATA_W-2:0], 1'b0};
`endif

    assign ICount = TXCount[ICOUNT_W-1:0] - ICOUNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0        <= '0;
            buf1        <= '0;
            txbit       <= 1'b0;
            txbit_valid <= 1'b0;
            TXCount     <= '0;
            underrun    <= 1'b0;
        end else begin
            if (LoadTXBuf0) begin
                buf0 <= ld0_val;
            end else if (sh0) begin
                buf0 <= sh0_val;
            end
            if (LoadTXBuf1) begin
                buf1 <= ld1_val;
            end else if (sh1) begin
                buf1 <= sh1_val;
            end

            if (sh0) begin
                txbit <= out0;
            end else if (sh1) begin
                txbit <= out1;
            end
            txbit_valid <= validdata && (ShiftTXBuf0 || ShiftTXBuf1);

            // Wrap at 1 so back-to-back bytes need no reload; 0 only exists before the first load.
            if (LoadTXCount) begin
                TXCount <= TXCOUNT_W'(DATA_W);
            end else if (DecTXCount) begin
                if (TXCount == TXCOUNT_W'(1)) begin
                    TXCount <= TXCOUNT_W'(DATA_W);
                end else if (TXCount != '0) begin
                    TXCount <= TXCount - TXCOUNT_W'(1);
                end
            end

            if (ld_under) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tx_shift_datapath.sv
// Bench for tx_shift_datapath: directed scenarios then random commands against a queue-based model.
// Honours TX_LSB_FIRST_EN to match the shift direction of the design build.
module tb_tx_shift_datapath;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic       LoadTXBuf0, LoadTXBuf1, ShiftTXBuf0, ShiftTXBuf1;
    logic       LoadTXCount, DecTXCount, validdata, underrun_clr;
    logic       txbit, txbit_valid;
    logic [6:0] TXCount;
    logic [2:0] ICount;
    logic       fifo_empty, underrun;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    int m_buf0, m_buf1, m_tx, m_vld, m_cnt, m_und;

    always #5 clk = ~clk;

    tx_shift_datapath #(.DATA_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .LoadTXBuf0   (LoadTXBuf0),
        .LoadTXBuf1   (LoadTXBuf1),
        .ShiftTXBuf0  (ShiftTXBuf0),
        .ShiftTXBuf1  (ShiftTXBuf1),
        .LoadTXCount  (LoadTXCount),
        .DecTXCount   (DecTXCount),
        .validdata    (validdata),
        .underrun_clr (underrun_clr),
        .txbit        (txbit),
        .txbit_valid  (txbit_valid),
        .TXCount      (TXCount),
        .ICount       (ICount),
        .fifo_empty   (fifo_empty),
        .underrun     (underrun)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int out_bit(input int b);
`ifdef TX_LSB_FIRST_EN
        return b & 1;
`else
        return (b >> 7) & 1;
`endif
    endfunction

    function automatic int shifted(input int b);
`ifdef TX_LSB_FIRST_EN
        return b >> 1;
`else
        return (b << 1) & 8'hFF;
`endif
    endfunction

    function automatic int take_byte();
        if (q.size() == 0) begin
            m_und = 1;
            return 0;
        end
        return q.pop_front();
    endfunction

    task automatic idle();
        rst = 0; wr_valid = 0; wr_data = 8'h00;
        LoadTXBuf0 = 0; LoadTXBuf1 = 0; ShiftTXBuf0 = 0; ShiftTXBuf1 = 0;
        LoadTXCount = 0; DecTXCount = 0; validdata = 0; underrun_clr = 0;
    endtask

    // Advance the model by one command cycle, clock the DUT, then compare every output.
    task automatic step();
        bit accept;
        int set_und;
        if (rst) begin
            q.delete();
            m_buf0 = 0; m_buf1 = 0; m_tx = 0; m_vld = 0; m_cnt = 0; m_und = 0;
        end else begin
            accept  = wr_valid && (q.size() < DEPTH);
            set_und = m_und;
            m_und   = 0;
            if (ShiftTXBuf0 && !LoadTXBuf0) begin
                m_tx = out_bit(m_buf0); m_buf0 = shifted(m_buf0);
            end else if (!ShiftTXBuf0 && ShiftTXBuf1 && !LoadTXBuf1) begin
                m_tx = out_bit(m_buf1); m_buf1 = shifted(m_buf1);
            end
            if (LoadTXBuf0) m_buf0 = take_byte();
            if (LoadTXBuf1) m_buf1 = take_byte();
            if (m_und == 0) m_und = (set_und != 0 && !underrun_clr) ? 1 : 0;
            m_vld = (validdata && (ShiftTXBuf0 || ShiftTXBuf1)) ? 1 : 0;
            if (LoadTXCount) m_cnt = 8;
            else if (DecTXCount) m_cnt = (m_cnt == 1) ? 8 : (m_cnt == 0 ? 0 : m_cnt - 1);
            if (accept) q.push_back(int'(wr_data));
        end
        @(posedge clk);
        #1;
        check("txbit", txbit, m_tx);
        check("txbit_valid", txbit_valid, m_vld);
        check("TXCount", TXCount, m_cnt);
        check("ICount", ICount, (m_cnt + 7) % 8);
        check("fifo_empty", fifo_empty, q.size() == 0);
        check("wr_ready", wr_ready, q.size() < DEPTH);
        check("underrun", underrun, m_und);
    endtask

    task automatic push(input logic [7:0] d);
        idle(); wr_valid = 1; wr_data = d; step(); idle();
    endtask

    // Shift one buffer 8 times with validdata and counter decrement; returns bits in emit order.
    task automatic shift8(input bit which, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < 8; i++) begin
            idle(); ShiftTXBuf0 = !which; ShiftTXBuf1 = which; validdata = 1; DecTXCount = 1;
            step();
            got = {got[6:0], txbit};
        end
        idle();
    endtask

    logic [7:0] got;

    initial begin
        idle();
        rst = 1; step(); step(); idle();
        check("rst_ICount", ICount, 7);
        check("rst_TXCount", TXCount, 0);

        // Counter at zero with decrement stays put.
        DecTXCount = 1; step(); idle();
        check("cnt0_dec", TXCount, 0);

        // Dual load of A5/3C, count load, shift buf0 out.
        push(8'hA5); push(8'h3C);
        LoadTXBuf0 = 1; LoadTXBuf1 = 1; step(); idle();
        LoadTXCount = 1; step(); idle();
        check("cnt_load", TXCount, 8);
        shift8(0, got);
        check("seq_A5", got, 8'hA5);
        check("cnt_wrap", TXCount, 8);
        shift8(1, got);
        check("seq_3C", got, 8'h3C);

        // Empty load forces underrun; clear drops it.
        LoadTXBuf0 = 1; step(); idle();
        check("underrun_set", underrun, 1);
        underrun_clr = 1; step(); idle();
        check("underrun_clr", underrun, 0);

        // Fill, then push+pop at full: the 5th byte is refused.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        check("full_rdy", wr_ready, 0);
        wr_valid = 1; wr_data = 8'h55; LoadTXBuf0 = 1; step(); idle();
        check("after_pp_rdy", wr_ready, 1);
        LoadTXBuf1 = 1; step(); idle();
        LoadTXBuf0 = 1; LoadTXBuf1 = 1; step(); idle();
        check("drained", fifo_empty, 1);
        check("no_under", underrun, 0);
        shift8(1, got);
        check("seq_44", got, 8'h44);

        // Both shifts: buf0 wins, buf1 untouched.
        push(8'h80); push(8'hFF);
        LoadTXBuf0 = 1; LoadTXBuf1 = 1; step(); idle();
        ShiftTXBuf0 = 1; ShiftTXBuf1 = 1; step(); idle();
`ifdef TX_LSB_FIRST_EN
        check("both_shift_bit", txbit, 0);
`else
        check("both_shift_bit", txbit, 1);
`endif
        shift8(1, got);
        check("buf1_held", got, 8'hFF);

        // Reset mid-byte.
        push(8'hF0); push(8'h77);
        LoadTXBuf0 = 1; LoadTXCount = 1; step(); idle();
        for (int i = 0; i < 3; i++) begin
            ShiftTXBuf0 = 1; validdata = 1; DecTXCount = 1; step(); idle();
        end
        rst = 1; step(); idle();
        check("rst_mid_txbit", txbit, 0);
        check("rst_mid_empty", fifo_empty, 1);
        shift8(0, got);
        check("rst_buf_zero", got, 8'h00);

        // Shift direction with 0x01.
        push(8'h01);
        LoadTXBuf0 = 1; step(); idle();
        shift8(0, got);
`ifdef TX_LSB_FIRST_EN
        check("seq_01", got, 8'h80);
`else
        check("seq_01", got, 8'h01);
`endif

        // Random commands against the model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst          = ($urandom_range(0, 199) == 0);
            wr_valid     = ($urandom_range(0, 9) < 5);
            wr_data      = 8'($urandom);
            LoadTXBuf0   = ($urandom_range(0, 9) == 0);
            LoadTXBuf1   = ($urandom_range(0, 9) == 0);
            ShiftTXBuf0  = ($urandom_range(0, 9) < 4);
            ShiftTXBuf1  = ($urandom_range(0, 9) < 3);
            LoadTXCount  = ($urandom_range(0, 19) == 0);
            DecTXCount   = ($urandom_range(0, 9) < 5);
            validdata    = ($urandom_range(0, 9) < 7);
            underrun_clr = ($urandom_range(0, 9) == 0);
            step();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
